// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: client request/ack bundle and scheduler status for uart_tx_sched.
interface uart_tx_sched_if;
    logic [1:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] ack;
    logic       grant_id;
    logic       busy;
    modport master (output req, data0, data1, input ack, grant_id, busy);
    modport slave (input req, data0, data1, output ack, grant_id, busy);
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-client round-robin arbiter feeding one 8N1 UART transmitter.
module uart_tx_sched #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic             sys_clk,
    input  logic             rst,
    uart_tx_sched_if.slave   bus,
    output logic             tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       sh;
    logic             last_served;
    logic             win;
    logic             cnt_end;
    always_comb begin
        win     = (bus.req == 2'b11) ? ~last_served : bus.req[1];
        cnt_end = cnt == CNT_W'(CLKS_PER_BIT - 1);
    end
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            sh           <= '0;
            last_served  <= 1'b1;
            tx           <= 1'b1;
            bus.ack      <= '0;
            bus.grant_id <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.ack <= '0;
            cnt     <= cnt_end ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (|bus.req) begin
                        sh           <= win ? bus.data1 : bus.data0;
                        bus.ack      <= {win, ~win};
                        bus.grant_id <= win;
                        last_served  <= win;
                        bus.busy     <= 1'b1;
                        tx           <= 1'b0;
                        state        <= START;
                    end
                end
                START: if (cnt_end) begin
                    state <= DATA;
                    idx   <= '0;
                    tx    <= sh[0];
                end
                DATA: if (cnt_end) begin
                    // last data bit rolls straight into the stop bit
                    if (idx == 3'd7) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                        sh  <= sh >> 1;
                        tx  <= sh[1];
                    end
                end
                STOP: if (cnt_end) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed table plus hand sequences for three bit-period settings.
module tb_uart_tx_sched;
    logic sys_clk = 1'b0;
    logic rst = 1'b1;
    always #5 sys_clk = ~sys_clk;
    uart_tx_sched_if i4 ();
    uart_tx_sched_if i2 ();
    uart_tx_sched_if i434 ();
    logic tx4, tx2, tx434;
    uart_tx_sched #(.CLKS_PER_BIT(4)) dut4 (.sys_clk(sys_clk), .rst(rst), .bus(i4), .tx(tx4));
    uart_tx_sched #(.CLKS_PER_BIT(2)) dut2 (.sys_clk(sys_clk), .rst(rst), .bus(i2), .tx(tx2));
    uart_tx_sched #(.CLKS_PER_BIT(434)) dut434 (.sys_clk(sys_clk), .rst(rst), .bus(i434), .tx(tx434));
    logic [1:0] req_v [3];
    logic [7:0] d0_v [3];
    logic [7:0] d1_v [3];
    logic [1:0] ack_o [3];
    logic       gid_o [3];
    logic       busy_o [3];
    logic       tx_o [3];
    assign i4.req = req_v[0];
    assign i4.data0 = d0_v[0];
    assign i4.data1 = d1_v[0];
    assign i2.req = req_v[1];
    assign i2.data0 = d0_v[1];
    assign i2.data1 = d1_v[1];
    assign i434.req = req_v[2];
    assign i434.data0 = d0_v[2];
    assign i434.data1 = d1_v[2];
    assign ack_o[0] = i4.ack;
    assign ack_o[1] = i2.ack;
    assign ack_o[2] = i434.ack;
    assign gid_o[0] = i4.grant_id;
    assign gid_o[1] = i2.grant_id;
    assign gid_o[2] = i434.grant_id;
    assign busy_o[0] = i4.busy;
    assign busy_o[1] = i2.busy;
    assign busy_o[2] = i434.busy;
    assign tx_o[0] = tx4;
    assign tx_o[1] = tx2;
    assign tx_o[2] = tx434;
    int n_cmp = 0;
    int n_bad = 0;
    typedef struct {
        int         unit;
        int         c;
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_ack;
        logic       exp_gid;
        logic [9:0] frame;
    } vec_t;
    vec_t vt [7];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // frame[k] is the k-th bit on the line: start, 8 data LSB first, stop
    task automatic run_frame(input int n, input vec_t v);
        int u;
        u = v.unit;
        req_v[u] = v.req;
        d0_v[u] = v.d0;
        d1_v[u] = v.d1;
        @(negedge sys_clk);
        chk($sformatf("v%0d.ack", n), 32'(ack_o[u]), 32'(v.exp_ack));
        chk($sformatf("v%0d.gid", n), 32'(gid_o[u]), 32'(v.exp_gid));
        req_v[u] = 2'b00;
        for (int j = 0; j < 10 * v.c; j++) begin
            if (j > 0) begin
                @(negedge sys_clk);
                chk($sformatf("v%0d.ack@%0d", n, j), 32'(ack_o[u]), 32'd0);
            end
            chk($sformatf("v%0d.tx@%0d", n, j), 32'(tx_o[u]), 32'(v.frame[j / v.c]));
            chk($sformatf("v%0d.busy@%0d", n, j), 32'(busy_o[u]), 32'd1);
        end
        @(negedge sys_clk);
        chk($sformatf("v%0d.busy_end", n), 32'(busy_o[u]), 32'd0);
        chk($sformatf("v%0d.tx_end", n), 32'(tx_o[u]), 32'd1);
    endtask
    initial begin
        vt[0] = '{0, 4, 2'b01, 8'hA5, 8'h00, 2'b01, 1'b0, 10'h34A};
        vt[1] = '{0, 4, 2'b10, 8'h00, 8'h3C, 2'b10, 1'b1, 10'h278};
        vt[2] = '{0, 4, 2'b11, 8'h0F, 8'hF0, 2'b01, 1'b0, 10'h21E};
        vt[3] = '{0, 4, 2'b11, 8'h0F, 8'hF0, 2'b10, 1'b1, 10'h3E0};
        vt[4] = '{0, 4, 2'b11, 8'h81, 8'h18, 2'b01, 1'b0, 10'h302};
        vt[5] = '{1, 2, 2'b10, 8'h00, 8'h80, 2'b10, 1'b1, 10'h300};
        vt[6] = '{2, 434, 2'b01, 8'h55, 8'h00, 2'b01, 1'b0, 10'h2AA};
        for (int u = 0; u < 3; u++) begin
            req_v[u] = 2'b00;
            d0_v[u] = 8'h00;
            d1_v[u] = 8'h00;
        end
        repeat (2) @(negedge sys_clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst.tx%0d", u), 32'(tx_o[u]), 32'd1);
            chk($sformatf("rst.busy%0d", u), 32'(busy_o[u]), 32'd0);
            chk($sformatf("rst.ack%0d", u), 32'(ack_o[u]), 32'd0);
            chk($sformatf("rst.gid%0d", u), 32'(gid_o[u]), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 7; i++) run_frame(i, vt[i]);
        // continuous double request: alternating grants, 41-cycle start spacing
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        req_v[0] = 2'b11;
        d0_v[0] = 8'h00;
        d1_v[0] = 8'hFF;
        for (int j = 0; j < 4 * 41; j++) begin
            int k, p;
            logic [9:0] fr;
            @(negedge sys_clk);
            k = j / 41;
            p = j % 41;
            fr = (k % 2 == 1) ? 10'h3FE : 10'h200;
            chk($sformatf("cont.busy@%0d", j), 32'(busy_o[0]), (p < 40) ? 32'd1 : 32'd0);
            chk($sformatf("cont.tx@%0d", j), 32'(tx_o[0]), (p < 40) ? 32'(fr[p / 4]) : 32'd1);
            chk($sformatf("cont.ack@%0d", j), 32'(ack_o[0]), (p != 0) ? 32'd0 : (k % 2 == 1) ? 32'd2 : 32'd1);
            if (p < 40) chk($sformatf("cont.gid@%0d", j), 32'(gid_o[0]), 32'(k % 2));
        end
        req_v[0] = 2'b00;
        repeat (3) begin
            @(negedge sys_clk);
            chk("cont.after_busy", 32'(busy_o[0]), 32'd0);
        end
        // req pulsed while busy must be ignored
        begin
            int n_ack, n_rise;
            logic pb;
            req_v[0] = 2'b01;
            d0_v[0] = 8'hC3;
            @(negedge sys_clk);
            chk("pulse.first_ack", 32'(ack_o[0]), 32'd1);
            req_v[0] = 2'b00;
            repeat (10) @(negedge sys_clk);
            req_v[0] = 2'b10;
            d1_v[0] = 8'h77;
            @(negedge sys_clk);
            req_v[0] = 2'b00;
            n_ack = 0;
            n_rise = 0;
            pb = busy_o[0];
            for (int j = 0; j < 80; j++) begin
                @(negedge sys_clk);
                if (ack_o[0] != 2'b00) n_ack++;
                if (busy_o[0] && !pb) n_rise++;
                pb = busy_o[0];
            end
            chk("pulse.acks", 32'(n_ack), 32'd0);
            chk("pulse.new_frames", 32'(n_rise), 32'd0);
            chk("pulse.busy_end", 32'(busy_o[0]), 32'd0);
        end
        // reset mid-frame while tx is low; last_served returns to 1
        req_v[0] = 2'b01;
        d0_v[0] = 8'h00;
        @(negedge sys_clk);
        req_v[0] = 2'b00;
        repeat (15) @(negedge sys_clk);
        chk("mid.tx_before", 32'(tx_o[0]), 32'd0);
        rst = 1'b1;
        @(negedge sys_clk);
        chk("mid.tx", 32'(tx_o[0]), 32'd1);
        chk("mid.busy", 32'(busy_o[0]), 32'd0);
        chk("mid.ack", 32'(ack_o[0]), 32'd0);
        rst = 1'b0;
        req_v[0] = 2'b11;
        d0_v[0] = 8'h5A;
        d1_v[0] = 8'hA5;
        @(negedge sys_clk);
        chk("mid.regrant_ack", 32'(ack_o[0]), 32'd1);
        chk("mid.regrant_gid", 32'(gid_o[0]), 32'd0);
        req_v[0] = 2'b00;
        repeat (45) @(negedge sys_clk);
        chk("mid.final_busy", 32'(busy_o[0]), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
